// File: rtl/inst_prefetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : inst_prefetch_buf
// Purpose  : Instruction-fetch front end between the core fetch stage and a
//            variable-latency request/grant instruction memory. Keeps several
//            fetches in flight and queues returned words, each tagged with its
//            PC, in a DEPTH-entry FIFO. A redirect flushes the queue and
//            discards responses to fetches issued before it.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            mem_req_o/addr_o    - fetch request and word-aligned address
//            mem_gnt_i           - memory accepted the current request
//            mem_rvalid_i/rdata_i- in-order response and its instruction word
//            inst_valid_o/inst_o/inst_pc_o - FIFO head towards the core
//            inst_ready_i        - core consumes the head
//            redirect_i/redirect_pc_i - flush and restart fetch at a new PC
// Revision : 1.0 - initial release
// ============================================================================
module inst_prefetch_buf #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h1c000000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              inst_ready_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [CW-1:0]     count;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_cnt;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [CW:0]   credit_sum;
  logic          grant;
  logic          push;
  logic          pop;
  logic [CW-1:0] outstanding_nxt;

  // Every queued entry and every in-flight request holds one FIFO slot, so a
  // request is only issued when a slot is guaranteed for its response.
  assign credit_sum = {1'b0, count} + {1'b0, outstanding};
  assign mem_req_o  = !rst && !redirect_i && (credit_sum < (CW+1)'(DEPTH));
  assign mem_addr_o = fetch_pc;
  assign grant      = mem_req_o && mem_gnt_i;

  // A response in the redirect cycle belongs to the old stream: never kept.
  assign push = mem_rvalid_i && !redirect_i && (drop_cnt == '0);
  assign pop  = inst_valid_o && inst_ready_i && !redirect_i;

  assign outstanding_nxt = outstanding + CW'(grant) - CW'(mem_rvalid_i);

  assign inst_valid_o = !rst && (count != '0);
  assign inst_o       = data_mem[rd_ptr];
  assign inst_pc_o    = pc_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_i) begin
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fetch_pc <= redirect_pc_i;
        resp_pc  <= redirect_pc_i;
        // Everything still in flight after this cycle is from the old stream.
        drop_cnt <= outstanding_nxt;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + PC_STEP;
        end
        if (mem_rvalid_i && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (push) begin
          resp_pc <= resp_pc + PC_STEP;
          wr_ptr  <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= resp_pc;
      data_mem[wr_ptr] <= mem_rdata_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_prefetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_prefetch_buf
// Purpose  : Self-checking bench for inst_prefetch_buf. Drives a randomized
//            in-order variable-latency memory, random core back-pressure,
//            redirects and resets, and checks every output against a
//            queue-based reference of the fetch stream.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_prefetch_buf;

  localparam int          ADDR_W   = 32;
  localparam int          DATA_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam int          NCYC     = 3000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i = 1'b0;
  logic              mem_rvalid_i = 1'b0;
  logic [DATA_W-1:0] mem_rdata_i = '0;
  logic              inst_valid_o;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_pc_o;
  logic              inst_ready_i = 1'b0;
  logic              redirect_i = 1'b0;
  logic [ADDR_W-1:0] redirect_pc_i = '0;

  inst_prefetch_buf #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_ready_i (inst_ready_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Distinct content per address so a lost, duplicated or stale word shows up.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  // Reference: the ordered stream of PCs the core should see, plus how many
  // requests are in flight and how many of those belong to a flushed stream.
  logic [31:0] m_fifo[$];
  logic [31:0] m_fetch;
  logic [31:0] m_resp;
  int          m_out;
  int          m_drop;

  // Memory: granted addresses with the cycle their response becomes due.
  logic [31:0] mq[$];
  int          dq[$];
  int          last_due;

  int pops_steady;

  initial begin
    logic        rst_v, gnt_v, rdy_v, red_v, rv_v, exp_req, exp_valid, grant;
    logic [31:0] rpc_v, rnd;
    int          lat_v;

    m_fetch = RESET_PC; m_resp = RESET_PC; m_out = 0; m_drop = 0;
    last_due = 0; pops_steady = 0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      // ---- choose stimulus for this cycle by phase ----
      rst_v = (cyc < 3);
      gnt_v = 1'b1; rdy_v = 1'b1; red_v = 1'b0; rpc_v = 32'h0; lat_v = 1;
      if (cyc >= 40 && cyc < 80) begin
        rdy_v = (cyc >= 60);                      // fill the FIFO, then drain
      end else if (cyc >= 80 && cyc < 140) begin
        lat_v = 5;
        if (cyc == 100) begin red_v = 1'b1; rpc_v = 32'h1c000100; end
      end else if (cyc >= 140 && cyc < 200) begin
        gnt_v = ((cyc % 4) == 3);                 // grant stalls of 3 cycles
        if (cyc == 170) begin red_v = 1'b1; rpc_v = 32'h1c000200; end
        if (cyc == 190) rst_v = 1'b1;             // reset mid-stream
      end else if (cyc >= 200) begin
        rst_v = ($urandom_range(99) == 0);
        gnt_v = ($urandom_range(9) < 7);
        rdy_v = ($urandom_range(9) < 6);
        red_v = ($urandom_range(19) == 0);
        rnd   = $urandom;
        rpc_v = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : (rnd & 32'hFFFF_FFFC);
        lat_v = $urandom_range(6, 1);
      end

      if (rst_v) begin
        mq.delete(); dq.delete(); last_due = 0;
      end
      rv_v = !rst_v && (dq.size() > 0) && (dq[0] <= cyc);

      rst           = rst_v;
      mem_gnt_i     = gnt_v;
      inst_ready_i  = rdy_v;
      redirect_i    = red_v;
      redirect_pc_i = rpc_v;
      mem_rvalid_i  = rv_v;
      mem_rdata_i   = rv_v ? rom(mq[0]) : $urandom;
      #1;

      // ---- compare against the reference ----
      exp_req   = !rst_v && !red_v && ((m_fifo.size() + m_out) < DEPTH);
      exp_valid = !rst_v && (m_fifo.size() != 0);
      check("mem_req", {63'd0, mem_req_o}, {63'd0, exp_req});
      check("inst_valid", {63'd0, inst_valid_o}, {63'd0, exp_valid});
      if (exp_req)
        check("mem_addr", {32'd0, mem_addr_o}, {32'd0, m_fetch});
      if (exp_valid && inst_valid_o) begin
        check("inst_pc", {32'd0, inst_pc_o}, {32'd0, m_fifo[0]});
        check("inst_data", {32'd0, inst_o}, {32'd0, rom(m_fifo[0])});
      end

      // Steady state of the first phase must deliver one instruction per cycle.
      if (cyc >= 10 && cyc < 40 && exp_valid && rdy_v) pops_steady++;
      if (cyc == 39) check("steady_rate", 64'(pops_steady), 64'd30);

      // ---- advance the reference to what the coming edge does ----
      if (rst_v) begin
        m_fifo.delete();
        m_fetch = RESET_PC; m_resp = RESET_PC; m_out = 0; m_drop = 0;
      end else begin
        grant = exp_req && gnt_v;
        if (exp_valid && rdy_v && !red_v) void'(m_fifo.pop_front());
        if (rv_v) begin
          void'(mq.pop_front()); void'(dq.pop_front());
          m_out--;
          if (!red_v) begin
            if (m_drop > 0) m_drop--;
            else begin m_fifo.push_back(m_resp); m_resp += 32'd4; end
          end
        end
        if (grant) begin
          m_out++;
          mq.push_back(m_fetch);
          last_due = (cyc + lat_v > last_due) ? cyc + lat_v : last_due;
          dq.push_back(last_due);
          m_fetch += 32'd4;
        end
        if (red_v) begin
          m_fifo.delete();
          m_fetch = rpc_v; m_resp = rpc_v;
          m_drop = m_out;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
